paged_mmu_ctrl: RTL
===================

// Module: paged_mmu_ctrl
// PURPOSE
//  Registered, multi-process successor to the combinational address translator.
//  Holds a base/limit table of NUM_PROC entries written by the OS, and a current-process register.
//  Translates each logical address to a physical address with bounds checking, and records faults.
//  Sits between the CPU address path and instruction/data memory. BiosSign bypasses translation.
// PARAMETERS
//  ADDR_W     32  width of logical/physical addresses, base and limit
//  NUM_PROC   8   table entries (power of 2, >=2)
//  IDX_W      3   log2(NUM_PROC)
//  LEGACY_DEC 1   1: subtract 1 from nonzero logical addresses (1-based program images); 0: none
//  FCNT_W     8   width of saturating fault counter
// PORTS
//  Clock        in   1       rising-edge clock
//  Reset        in   1       asynchronous, active-low reset
//  BiosSign     in   1       1: identity mapping, no limit check
//  TableWe      in   1       write TableBase/TableLimit into entry TableIdx
//  TableIdx     in   IDX_W   entry to write
//  TableBase    in   ADDR_W  segment base
//  TableLimit   in   ADDR_W  segment size in words (0 = empty segment)
//  ProcWe       in   1       load ProcSel into the current-process register
//  ProcSel      in   IDX_W   new current process
//  ReqValid     in   1       translation request this cycle
//  LogicalAddr  in   ADDR_W  address to translate
//  RespValid    out  1       response valid (1 cycle after ReqValid)
//  PhysAddr     out  ADDR_W  translated address (0 when RespFault)
//  RespFault    out  1       request violated limit/overflow
//  FaultPend    out  1       sticky fault flag
//  FaultAddr    out  ADDR_W  logical address of first pending fault
//  FaultProc    out  IDX_W   process that caused it
//  FaultClear   in   1       clears FaultPend/FaultAddr/FaultProc
//  FaultCount   out  FCNT_W  saturating count of faults since reset
// BEHAVIOUR
//  Reset (async, Reset=0): all table entries base=0/limit=0; current process 0; every output 0.
//  Table write: on the clock edge with TableWe=1. The entry is visible to requests from the next cycle.
//  Process select: on the clock edge with ProcWe=1. The new value applies to requests from the next cycle.
//  Same-cycle ReqValid + TableWe/ProcWe: the request uses the pre-write (old) entry/process.
//  Pipeline: 1 stage, one request per cycle, no backpressure.
//   RespValid(n+1)=ReqValid(n). When RespValid=0, PhysAddr and RespFault hold 0.
//  Translation for request at cycle n (B,L = entry of current process):
//   - BiosSign=1: PhysAddr=LogicalAddr, RespFault=0, LEGACY_DEC not applied.
//   - else dec = (LEGACY_DEC && LogicalAddr!=0) ? 1 : 0
//   - eff = LogicalAddr - dec, computed in ADDR_W bits.
//   - fault if eff >= L, or if B + eff carries out of ADDR_W bits.
//   - no fault: PhysAddr = B + eff (ADDR_W bits); fault: PhysAddr=0, RespFault=1.
//  Fault capture: on a faulting response with FaultPend=0, set FaultPend=1 and latch LogicalAddr and the process.
//   Later faults do not overwrite the latched values while FaultPend=1.
//  FaultClear=1: clears FaultPend/FaultAddr/FaultProc on that edge.
//   A fault in the same cycle wins: it sets FaultPend and latches the new fault.
//  FaultCount increments on each faulting response and saturates at all-ones. Only Reset clears it.
//  Reset asserted mid-request: the in-flight response is dropped; RespValid=0 immediately.
// TESTING
//  Reset, read all outputs -> all 0; request LogicalAddr=5 on proc0 (limit 0), BiosSign=0 -> RespFault=1, FaultCount=1.
//  Entry2 base=0x1000 limit=0x100; ProcSel=2; LogicalAddr 0 -> PhysAddr 0x1000; 0x10 -> 0x100F; 0x100 -> 0x10FF; 0x101 -> fault, FaultAddr=0x101, FaultProc=2.
//  BiosSign=1, LogicalAddr=0x1234 -> PhysAddr=0x1234, no fault, regardless of table contents.
//  Request + TableWe to the current entry (base 0x1000->0x2000) same cycle -> old base used (0x1000+eff); next request uses 0x2000.
//  Two faults, then FaultClear together with a third fault -> FaultPend=1, FaultAddr=third address, FaultCount=3; drive FaultCount past 255 -> stays 255.
//  Base 0xFFFFFFF0 limit 0x100, LogicalAddr 0x20 -> carry-out fault, PhysAddr=0; assert Reset mid-burst -> RespValid drops at once.

Source files
------------

// File: rtl/paged_mmu_ctrl.sv
// paged_mmu_ctrl: registered multi-process base/limit address translator with fault capture.
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   bios_sign_i      identity mapping, no limit check
//   table_we_i       write table_base_i/table_limit_i into entry table_idx_i
//   table_idx_i      entry to write
//   table_base_i     segment base
//   table_limit_i    segment size in words (0 = empty segment)
//   proc_we_i        load proc_sel_i into the current-process register
//   proc_sel_i       new current process
//   req_valid_i      translation request this cycle
//   logical_addr_i   address to translate
//   resp_valid_o     response valid, one cycle after req_valid_i
//   phys_addr_o      translated address (0 on fault or no response)
//   resp_fault_o     request violated limit or overflowed
//   fault_pend_o     sticky fault flag
//   fault_addr_o     logical address of the first pending fault
//   fault_proc_o     process that caused it
//   fault_clear_i    clears the pending fault record
//   fault_count_o    saturating count of faults since reset
module paged_mmu_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int NUM_PROC   = 8,
   parameter int IDX_W      = 3,
   parameter int LEGACY_DEC = 1,
   parameter int FCNT_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              bios_sign_i,
   input  logic              table_we_i,
   input  logic [IDX_W-1:0]  table_idx_i,
   input  logic [ADDR_W-1:0] table_base_i,
   input  logic [ADDR_W-1:0] table_limit_i,
   input  logic              proc_we_i,
   input  logic [IDX_W-1:0]  proc_sel_i,
   input  logic              req_valid_i,
   input  logic [ADDR_W-1:0] logical_addr_i,
   output logic              resp_valid_o,
   output logic [ADDR_W-1:0] phys_addr_o,
   output logic              resp_fault_o,
   output logic              fault_pend_o,
   output logic [ADDR_W-1:0] fault_addr_o,
   output logic [IDX_W-1:0]  fault_proc_o,
   input  logic              fault_clear_i,
   output logic [FCNT_W-1:0] fault_count_o
);
   logic [ADDR_W-1:0] base_q  [NUM_PROC];
   logic [ADDR_W-1:0] limit_q [NUM_PROC];
   logic [IDX_W-1:0]  proc_q;
   logic              resp_valid_q, resp_fault_q, pend_q;
   logic [ADDR_W-1:0] phys_q, faddr_q;
   logic [IDX_W-1:0]  fproc_q;
   logic [FCNT_W-1:0] fcnt_q;
   logic [ADDR_W-1:0] eff, sum, phys_d;
   logic              dec, carry, fault_d, flt_req;
   // Table and process reads use the registered (pre-write) values, so a
   // same-cycle write only affects later requests.
   always_comb begin
      dec             = (LEGACY_DEC != 0) && (logical_addr_i != '0);
      eff             = logical_addr_i - {{(ADDR_W-1){1'b0}}, dec};
      {carry, sum}    = {1'b0, base_q[proc_q]} + {1'b0, eff};
      fault_d         = !bios_sign_i && ((eff >= limit_q[proc_q]) || carry);
      phys_d          = bios_sign_i ? logical_addr_i : (fault_d ? '0 : sum);
      flt_req         = req_valid_i && fault_d;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_PROC; i++) begin
            base_q[i]  <= '0;
            limit_q[i] <= '0;
         end
         proc_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         phys_q       <= '0;
         pend_q       <= 1'b0;
         faddr_q      <= '0;
         fproc_q      <= '0;
         fcnt_q       <= '0;
      end else begin
         if (table_we_i) begin
            base_q[table_idx_i]  <= table_base_i;
            limit_q[table_idx_i] <= table_limit_i;
         end
         if (proc_we_i) proc_q <= proc_sel_i;
         resp_valid_q <= req_valid_i;
         resp_fault_q <= flt_req;
         phys_q       <= req_valid_i ? phys_d : '0;
         // A new fault beats a simultaneous clear and becomes the latched record.
         if (flt_req && (!pend_q || fault_clear_i)) begin
            pend_q  <= 1'b1;
            faddr_q <= logical_addr_i;
            fproc_q <= proc_q;
         end else if (fault_clear_i) begin
            pend_q  <= 1'b0;
            faddr_q <= '0;
            fproc_q <= '0;
         end
         if (flt_req && fcnt_q != '1) fcnt_q <= fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
      end
   end
   assign resp_valid_o  = resp_valid_q;
   assign phys_addr_o   = phys_q;
   assign resp_fault_o  = resp_fault_q;
   assign fault_pend_o  = pend_q;
   assign fault_addr_o  = faddr_q;
   assign fault_proc_o  = fproc_q;
   assign fault_count_o = fcnt_q;
endmodule
